// File: rtl/dct_state_ctrl.sv
// Sequencer for the DCT stage of the MFCC pipeline: walks every (cepstral, mel) pair,
// pacing the external multiplier, accumulator and MFCC write port with fixed latencies.
module dct_state_ctrl #(
    parameter int NUM_MEL     = 26,
    parameter int NUM_CEPS    = 13,
    parameter int LOOPS_MUL   = 10,
    parameter int LOOPS_ADD   = 10,
    parameter int LOOPS_WRITE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dct_state_en,
    output logic       mel_rd_en,
    output logic [4:0] mel_addr,
    output logic [8:0] cos_addr,
    output logic       mul_en,
    output logic       add_en,
    output logic       acc_clr,
    output logic       mfcc_wr_en,
    output logic [3:0] mfcc_addr,
    output logic       busy,
    output logic       dct_done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_READ,
        S_MUL,
        S_ADD,
        S_BRANCH,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [4:0] MEL_LAST   = 5'(NUM_MEL - 1);
    localparam logic [3:0] CEPS_LAST  = 4'(NUM_CEPS - 1);
    localparam logic [3:0] MUL_LAST   = 4'(LOOPS_MUL - 1);
    localparam logic [3:0] ADD_LAST   = 4'(LOOPS_ADD - 1);
    localparam logic [3:0] WRITE_LAST = 4'(LOOPS_WRITE - 1);

    state_t     state_q, state_d;
    logic [4:0] mel_idx_q, mel_idx_d;
    logic [3:0] ceps_idx_q, ceps_idx_d;
    logic [3:0] wait_q, wait_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mel_idx_q  <= '0;
            ceps_idx_q <= '0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            mel_idx_q  <= mel_idx_d;
            ceps_idx_q <= ceps_idx_d;
            wait_q     <= wait_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mel_idx_d  = mel_idx_q;
        ceps_idx_d = ceps_idx_q;
        case (state_q)
            S_IDLE: begin
                // Indices are zeroed on the way into START so START already shows address 0.
                if (dct_state_en) begin
                    state_d    = S_START;
                    mel_idx_d  = '0;
                    ceps_idx_d = '0;
                end
            end
            S_START: begin
                mel_idx_d  = '0;
                ceps_idx_d = '0;
                state_d    = S_READ;
            end
            S_READ: state_d = S_MUL;
            S_MUL: begin
                if (wait_q == MUL_LAST) state_d = S_ADD;
            end
            S_ADD: begin
                if (wait_q == ADD_LAST) state_d = S_BRANCH;
            end
            S_BRANCH: begin
                if (mel_idx_q == MEL_LAST) begin
                    state_d = S_WRITE;
                end else begin
                    mel_idx_d = mel_idx_q + 5'd1;
                    state_d   = S_READ;
                end
            end
            S_WRITE: begin
                if (wait_q == WRITE_LAST) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (ceps_idx_q == CEPS_LAST) begin
                    state_d = S_DONE;
                end else begin
                    ceps_idx_d = ceps_idx_q + 4'd1;
                    mel_idx_d  = '0;
                    state_d    = S_READ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The wait counter restarts on every state change and only runs in the timed states.
    always_comb begin
        wait_d = '0;
        if ((state_d == state_q) &&
            ((state_q == S_MUL) || (state_q == S_ADD) || (state_q == S_WRITE))) begin
            wait_d = wait_q + 4'd1;
        end
    end

    always_comb begin
        mel_rd_en  = 1'b0;
        mul_en     = 1'b0;
        add_en     = 1'b0;
        acc_clr    = 1'b0;
        mfcc_wr_en = 1'b0;
        dct_done   = 1'b0;
        busy       = (state_q != S_IDLE);
        case (state_q)
            S_START: acc_clr    = 1'b1;
            S_READ:  mel_rd_en  = 1'b1;
            S_MUL:   mul_en     = 1'b1;
            S_ADD:   add_en     = 1'b1;
            S_WRITE: mfcc_wr_en = 1'b1;
            S_NEXT:  acc_clr    = 1'b1;
            S_DONE:  dct_done   = 1'b1;
            default: ;
        endcase
    end

    assign mel_addr  = mel_idx_q;
    assign mfcc_addr = ceps_idx_q;
    assign cos_addr  = 9'(ceps_idx_q) * 9'(NUM_MEL) + 9'(mel_idx_q);

endmodule

// File: tb/tb_dct_state_ctrl.sv
// Bench for dct_state_ctrl: a reduced-parameter instance is driven from a per-cycle vector
// table; a default instance is checked cycle by cycle against a queue of expected frames.
`timescale 1ns/1ps
module tb_dct_state_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic en_m, en_s;

    logic       m_rd, m_mul, m_add, m_clr, m_wr, m_busy, m_done;
    logic [4:0] m_mel;
    logic [8:0] m_cos;
    logic [3:0] m_mfcc;
    logic       s_rd, s_mul, s_add, s_clr, s_wr, s_busy, s_done;
    logic [4:0] s_mel;
    logic [8:0] s_cos;
    logic [3:0] s_mfcc;

    dct_state_ctrl u_main (
        .clk(clk), .rst_n(rst_n), .dct_state_en(en_m),
        .mel_rd_en(m_rd), .mel_addr(m_mel), .cos_addr(m_cos),
        .mul_en(m_mul), .add_en(m_add), .acc_clr(m_clr),
        .mfcc_wr_en(m_wr), .mfcc_addr(m_mfcc), .busy(m_busy), .dct_done(m_done)
    );

    dct_state_ctrl #(
        .NUM_MEL(2), .NUM_CEPS(1), .LOOPS_MUL(1), .LOOPS_ADD(1), .LOOPS_WRITE(1)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .dct_state_en(en_s),
        .mel_rd_en(s_rd), .mel_addr(s_mel), .cos_addr(s_cos),
        .mul_en(s_mul), .add_en(s_add), .acc_clr(s_clr),
        .mfcc_wr_en(s_wr), .mfcc_addr(s_mfcc), .busy(s_busy), .dct_done(s_done)
    );

    // Control vector order: {busy, acc_clr, mel_rd_en, mul_en, add_en, mfcc_wr_en, dct_done}
    localparam logic [6:0] C_IDLE   = 7'b0000000;
    localparam logic [6:0] C_START  = 7'b1100000;
    localparam logic [6:0] C_READ   = 7'b1010000;
    localparam logic [6:0] C_MUL    = 7'b1001000;
    localparam logic [6:0] C_ADD    = 7'b1000100;
    localparam logic [6:0] C_BRANCH = 7'b1000000;
    localparam logic [6:0] C_WRITE  = 7'b1000010;
    localparam logic [6:0] C_NEXT   = 7'b1100000;
    localparam logic [6:0] C_DONE   = 7'b1000001;

    typedef struct {
        logic [6:0] ctl;
        logic       chk_rd;
        logic [4:0] mel;
        logic [8:0] cos;
        logic       chk_wr;
        logic [3:0] mfcc;
    } rec_t;

    typedef struct {
        logic       en;
        logic [6:0] ctl;
        logic       chk_a;
        logic [4:0] mel;
        logic [8:0] cos;
        logic [3:0] mfcc;
    } vec_t;

    rec_t sb[$];
    vec_t tbl[16];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [6:0] m_ctl();
        return {m_busy, m_clr, m_rd, m_mul, m_add, m_wr, m_done};
    endfunction

    function automatic logic [6:0] s_ctl();
        return {s_busy, s_clr, s_rd, s_mul, s_add, s_wr, s_done};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [6:0] ctl, input logic chk_rd, input int mel,
                        input int cos, input logic chk_wr, input int mfcc);
        rec_t r;
        r.ctl    = ctl;
        r.chk_rd = chk_rd;
        r.mel    = 5'(mel);
        r.cos    = 9'(cos);
        r.chk_wr = chk_wr;
        r.mfcc   = 4'(mfcc);
        sb.push_back(r);
    endtask

    // One full default-parameter frame: 26 x (READ, 10 MUL, 10 ADD, BRANCH) + 2 WRITE + NEXT per coefficient.
    task automatic gen_frame();
        push(C_START, 1'b0, 0, 0, 1'b0, 0);
        for (int c = 0; c < 13; c++) begin
            for (int m = 0; m < 26; m++) begin
                push(C_READ, 1'b1, m, c * 26 + m, 1'b0, 0);
                repeat (10) push(C_MUL, 1'b0, 0, 0, 1'b0, 0);
                repeat (10) push(C_ADD, 1'b0, 0, 0, 1'b0, 0);
                push(C_BRANCH, 1'b0, 0, 0, 1'b0, 0);
            end
            repeat (2) push(C_WRITE, 1'b0, 0, 0, 1'b1, c);
            push(C_NEXT, 1'b0, 0, 0, 1'b0, 0);
        end
        push(C_DONE, 1'b0, 0, 0, 1'b0, 0);
    endtask

    task automatic drain(input int max_cycles, input logic hold, output int n_rd,
                         output int n_burst, output int n_busy, output int done_at,
                         output int n_done);
        rec_t r;
        logic prev_wr;
        n_rd = 0; n_burst = 0; n_busy = 0; done_at = -1; n_done = 0;
        prev_wr = 1'b0;
        for (int k = 0; k < max_cycles; k++) begin
            if (sb.size() == 0) break;
            r = sb.pop_front();
            step();
            if (k == 0) en_m = hold;
            chk($sformatf("frame_ctl[%0d]", k), 32'(m_ctl()), 32'(r.ctl));
            if (r.chk_rd)
                chk($sformatf("frame_rd_addr[%0d]", k), {18'd0, m_mel, m_cos}, {18'd0, r.mel, r.cos});
            if (r.chk_wr)
                chk($sformatf("frame_mfcc_addr[%0d]", k), 32'(m_mfcc), 32'(r.mfcc));
            if (m_rd) n_rd++;
            if (m_wr && !prev_wr) n_burst++;
            prev_wr = m_wr;
            if (m_busy) n_busy++;
            if (m_done) begin
                n_done++;
                done_at = n_busy;
            end
        end
    endtask

    task automatic check_frame_counts(input string tag, input int n_rd, input int n_burst,
                                      input int n_busy, input int done_at, input int n_done);
        chk({tag, "_mel_rd_pulses"}, 32'(n_rd), 32'd338);
        chk({tag, "_mfcc_bursts"}, 32'(n_burst), 32'd13);
        chk({tag, "_busy_cycles"}, 32'(n_busy), 32'd7477);
        chk({tag, "_done_busy_cycle"}, 32'(done_at), 32'd7477);
        chk({tag, "_done_count"}, 32'(n_done), 32'd1);
        $display("frame %s: rd=%0d bursts=%0d busy=%0d done_at=%0d", tag, n_rd, n_burst, n_busy, done_at);
    endtask

    initial begin
        int n_rd, n_burst, n_busy, done_at, n_done, s_busy_cnt;

        tbl[0]  = '{1'b1, C_START,  1'b0, 5'd0, 9'd0, 4'd0};
        tbl[1]  = '{1'b0, C_READ,   1'b1, 5'd0, 9'd0, 4'd0};
        tbl[2]  = '{1'b0, C_MUL,    1'b0, 5'd0, 9'd0, 4'd0};
        tbl[3]  = '{1'b0, C_ADD,    1'b0, 5'd0, 9'd0, 4'd0};
        tbl[4]  = '{1'b1, C_BRANCH, 1'b0, 5'd0, 9'd0, 4'd0};
        tbl[5]  = '{1'b0, C_READ,   1'b1, 5'd1, 9'd1, 4'd0};
        tbl[6]  = '{1'b0, C_MUL,    1'b0, 5'd0, 9'd0, 4'd0};
        tbl[7]  = '{1'b1, C_ADD,    1'b0, 5'd0, 9'd0, 4'd0};
        tbl[8]  = '{1'b0, C_BRANCH, 1'b0, 5'd0, 9'd0, 4'd0};
        tbl[9]  = '{1'b0, C_WRITE,  1'b1, 5'd1, 9'd1, 4'd0};
        tbl[10] = '{1'b1, C_NEXT,   1'b0, 5'd0, 9'd0, 4'd0};
        tbl[11] = '{1'b0, C_DONE,   1'b0, 5'd0, 9'd0, 4'd0};
        tbl[12] = '{1'b0, C_IDLE,   1'b0, 5'd0, 9'd0, 4'd0};
        tbl[13] = '{1'b0, C_IDLE,   1'b0, 5'd0, 9'd0, 4'd0};
        tbl[14] = '{1'b1, C_START,  1'b0, 5'd0, 9'd0, 4'd0};
        tbl[15] = '{1'b0, C_READ,   1'b1, 5'd0, 9'd0, 4'd0};

        rst_n = 1'b1;
        en_m  = 1'b0;
        en_s  = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        chk("reset_main", {9'd0, m_ctl(), m_mel, m_cos, m_mfcc}, 32'd0);
        chk("reset_small", {9'd0, s_ctl(), s_mel, s_cos, s_mfcc}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post_reset_idle[%0d]", i), 32'(m_ctl()), 32'(C_IDLE));
        end

        // Reduced-parameter instance, one row per cycle.
        s_busy_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            en_s = tbl[i].en;
            step();
            chk($sformatf("small_ctl[%0d]", i), 32'(s_ctl()), 32'(tbl[i].ctl));
            if (tbl[i].chk_a)
                chk($sformatf("small_addr[%0d]", i), {14'd0, s_mel, s_cos, s_mfcc},
                    {14'd0, tbl[i].mel, tbl[i].cos, tbl[i].mfcc});
            if (i < 14 && s_busy) s_busy_cnt++;
            $display("small row %0d: en=%0b ctl=%07b mel=%0d cos=%0d mfcc=%0d",
                     i, tbl[i].en, s_ctl(), s_mel, s_cos, s_mfcc);
        end
        chk("small_busy_cycles", 32'(s_busy_cnt), 32'd12);
        en_s = 1'b0;

        // Single-cycle request, default parameters.
        en_m = 1'b1;
        gen_frame();
        drain(8000, 1'b0, n_rd, n_burst, n_busy, done_at, n_done);
        check_frame_counts("single", n_rd, n_burst, n_busy, done_at, n_done);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("single_after_idle[%0d]", i), 32'(m_ctl()), 32'(C_IDLE));
        end

        // Request held high for the whole frame: one DONE, one IDLE cycle, then a new START.
        en_m = 1'b1;
        gen_frame();
        drain(8000, 1'b1, n_rd, n_burst, n_busy, done_at, n_done);
        check_frame_counts("held", n_rd, n_burst, n_busy, done_at, n_done);
        step();
        chk("held_idle_after_done", 32'(m_ctl()), 32'(C_IDLE));
        step();
        chk("held_restart", 32'(m_ctl()), 32'(C_START));

        // Run the second frame into MUL of coefficient 5, then reset asynchronously.
        gen_frame();
        void'(sb.pop_front());
        drain(2878, 1'b0, n_rd, n_burst, n_busy, done_at, n_done);
        chk("pre_reset_in_mul", 32'(m_ctl()), 32'(C_MUL));
        chk("pre_reset_ceps5", 32'(m_mfcc), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {9'd0, m_ctl(), m_mel, m_cos, m_mfcc}, 32'd0);
        $display("async reset applied mid-frame at %0t", $time);
        sb.delete();
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("reset_release_idle[%0d]", i), 32'(m_ctl()), 32'(C_IDLE));
        end
        en_m = 1'b1;
        step();
        en_m = 1'b0;
        chk("fresh_start", 32'(m_ctl()), 32'(C_START));
        step();
        chk("fresh_read", 32'(m_ctl()), 32'(C_READ));
        chk("fresh_read_addr", {18'd0, m_mel, m_cos}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dct_state_ctrl.md
DCT_STATE_CTRL -- requirements
Module: dct_state_ctrl

Interface
REQ-001 Parameter NUM_MEL, default 26: number of log-mel energies read per frame.
REQ-002 Parameter NUM_CEPS, default 13: number of cepstral coefficients produced per frame.
REQ-003 Parameter LOOPS_MUL, default 10: multiplier latency in cycles, range 1..15.
REQ-004 Parameter LOOPS_ADD, default 10: adder latency in cycles, range 1..15.
REQ-005 Parameter LOOPS_WRITE, default 2: MFCC write-strobe length in cycles, range 1..15.
REQ-006 clk  input  1  single clock; all state changes on the rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 dct_state_en  input  1  start request, issued when the mel stage has written all NUM_MEL log energies.
REQ-009 mel_rd_en  output  1  read strobe to the mel log-energy buffer.
REQ-010 mel_addr  output  5  mel buffer address, equal to mel_idx.
REQ-011 cos_addr  output  9  cosine-table ROM address, equal to ceps_idx*NUM_MEL + mel_idx.
REQ-012 mul_en  output  1  enable to the floating-point multiplier.
REQ-013 add_en  output  1  enable to the floating-point accumulate adder.
REQ-014 acc_clr  output  1  clears the accumulator register.
REQ-015 mfcc_wr_en  output  1  write strobe to the MFCC output buffer.
REQ-016 mfcc_addr  output  4  MFCC buffer address, equal to ceps_idx.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 dct_done  output  1  one-cycle pulse when the frame completes.

Function
REQ-019 The block SHALL implement the Moore FSM IDLE, START, READ, MUL, ADD, BRANCH, WRITE, NEXT, DONE, with outputs decoded from the present state and the indices.
REQ-020 IDLE -> START when dct_state_en=1 is sampled; otherwise the FSM stays in IDLE. In IDLE all strobes are 0.
REQ-021 START (1 cycle): acc_clr=1; mel_idx and ceps_idx load 0; next state is READ.
REQ-022 READ (1 cycle): mel_rd_en=1; mel_addr and cos_addr driven from the current indices; next state is MUL.
REQ-023 MUL: mul_en=1 for exactly LOOPS_MUL cycles; then ADD.
REQ-024 ADD: add_en=1 for exactly LOOPS_ADD cycles; then BRANCH.
REQ-025 The MUL, ADD and WRITE durations SHALL come from an internal 4-bit wait counter:
- cleared on state entry;
- the state exits on the cycle where count = LOOPS_x-1.
REQ-026 BRANCH (1 cycle), all strobes 0:
- if mel_idx = NUM_MEL-1, go to WRITE;
- otherwise mel_idx increments and the FSM goes to READ.
REQ-027 WRITE: mfcc_wr_en=1 for exactly LOOPS_WRITE cycles, with mfcc_addr=ceps_idx; then NEXT.
REQ-028 NEXT (1 cycle): acc_clr=1.
- if ceps_idx = NUM_CEPS-1, go to DONE;
- otherwise ceps_idx increments, mel_idx loads 0, and the FSM goes to READ.
REQ-029 DONE (1 cycle): dct_done=1; next state is IDLE.
REQ-030 Frame length: with default parameters, busy SHALL be high for 7477 cycles (START=1, 13×575, DONE=1).
REQ-031 dct_state_en SHALL be ignored in every state except IDLE; a request during busy is dropped, not queued.
REQ-032 dct_state_en held high through DONE SHALL start a new frame from IDLE on the cycle after DONE.
REQ-033 Index arithmetic is unsigned; mel_idx and ceps_idx never wrap past NUM_MEL-1 and NUM_CEPS-1 respectively.
REQ-034 At most one of mel_rd_en, mul_en, add_en, mfcc_wr_en SHALL be high in any cycle.

Reset
REQ-035 rst_n=0 SHALL force IDLE asynchronously, at any state including mid-frame.
REQ-036 During reset: indices and wait counter = 0; all outputs = 0, addresses = 0.
REQ-037 After reset release, the block SHALL not start until a fresh dct_state_en=1 is sampled in IDLE.

Verification
REQ-038 Single pulse of dct_state_en in IDLE, default parameters:
- exactly 338 mel_rd_en pulses and 13 mfcc_wr_en bursts of 2 cycles;
- dct_done 7477 cycles after START entry.
REQ-039 Address walk:
- cos_addr sequence is 0,1,…,337;
- mel_addr cycles 0..25 per coefficient;
- mfcc_addr goes 0..12 in order.
REQ-040 dct_state_en held high for an entire frame: exactly one dct_done, then an immediate second frame starting with START.
REQ-041 rst_n asserted in MUL at ceps_idx=5: all outputs 0 in the same cycle; after release, the FSM stays in IDLE until dct_state_en=1.
REQ-042 NUM_MEL=2, NUM_CEPS=1, LOOPS_MUL=LOOPS_ADD=LOOPS_WRITE=1:
- state trace START,READ,MUL,ADD,BRANCH,READ,MUL,ADD,BRANCH,WRITE,NEXT,DONE;
- busy high for 12 cycles.
